qos_vc_router: RTL
==================

// Module: qos_vc_router
// PURPOSE
//  Parametrised QoS virtual-channel router: accepts DATA_W-bit words and demuxes each on its top VC_W
//  bits into NUM_VC per-channel FIFOs. Provides programmable almost-full/almost-empty thresholds, a
//  RESET/INIT/IDLE/ACTIVE/ERROR control FSM, and per-channel popped-word counters read by req/idx.
//  Sits between the upstream ingress FIFO and the downstream channel consumers. Generalises the fixed
//  4-channel, 12-bit QoS unit, and adds overflow/underflow error detection and input backpressure.
// PARAMETERS
//  DATA_W      12  word width; channel select = data_in[DATA_W-1 -: VC_W]
//  NUM_VC      4   number of virtual channels; power of two, >=2; VC_W = $clog2(NUM_VC)
//  FIFO_DEPTH  8   entries per channel FIFO; power of two; THR_W = $clog2(FIFO_DEPTH)+1
//  CNT_W       8   width of each word counter and of the total counter
// PORTS
//  clk           in   1             clock, all logic on rising edge
//  reset         in   1             asynchronous, active-low reset
//  init          in   1             1 = program thresholds / re-initialise
//  umbral_high   in   THR_W         almost-full threshold, latched while in INIT
//  umbral_low    in   THR_W         almost-empty threshold, latched while in INIT
//  push          in   1             write data_in into channel selected by its top bits
//  data_in       in   DATA_W        input word
//  ready_in      out  1             combinational: target channel (from data_in) not full
//  pop           in   NUM_VC        per-channel read strobes
//  data_out      out  NUM_VC*DATA_W channel i at [i*DATA_W +: DATA_W]
//  empty, almost_full, almost_empty  out NUM_VC  per-channel status flags
//  req           in   1             counter read request
//  idx           in   VC_W+1        0..NUM_VC-1 = channel count; NUM_VC = total count
//  valid         out  1             counter read data valid
//  data          out  CNT_W         counter read value
//  idle_out, active_out, error_out  out 1  FSM state indicators (one-hot with INIT/RESET)
// BEHAVIOUR
//  - reset low: FSM = RESET, all FIFOs empty, counters 0, thresholds 0, data_out/data 0, valid 0,
//    idle/active/error 0, empty all 1. Mid-operation reset discards all contents immediately.
//  - FSM: RESET -> INIT on the first clock after reset is released. INIT: latch umbral_* every cycle
//    while init=1 (last value wins), clear counters and FIFOs; init=0 -> IDLE.
//    IDLE: push accepted -> ACTIVE. ACTIVE: all FIFOs empty and no accepted push in the cycle -> IDLE.
//    Any of IDLE/ACTIVE: overflow or underflow -> ERROR. ERROR is sticky; init=1 -> INIT from
//    IDLE/ACTIVE/ERROR. push/pop are ignored in RESET and INIT.
//  - Write: push && ready_in stores data_in into the tail of its channel (1 cycle, visible next cycle).
//    push && !ready_in = overflow: word dropped, ERROR next cycle.
//  - Read: pop[i] with !empty[i] updates data_out[i] on the next edge (1-cycle latency); data_out[i]
//    holds between pops. pop[i] on an empty channel = underflow: no change, ERROR next cycle.
//  - Simultaneous push+pop on the same channel: both performed when legal. No empty-bypass, so pop on
//    an empty channel is an underflow even with a concurrent push. A full channel still refuses push.
//  - Flags (registered from next-state occupancy cnt): almost_full = cnt >= umbral_high;
//    almost_empty = cnt <= umbral_low; empty = cnt == 0. Width: cnt is THR_W bits, compared unsigned.
//  - Counters: each successful pop increments that channel's count and the total count; saturate at
//    2^CNT_W-1 (no wrap). Pops in the same cycle add together on total.
//  - Counter read: req=1 samples idx; the next cycle valid=1 and data=counter[idx]. idx>NUM_VC gives
//    valid=1, data=0. req=0 gives valid=0, data holds. Continuous req streams one read per cycle.
// STRUCTURE
//  - qos_pkg: FSM state encoding localparams (RESET, INIT, IDLE, ACTIVE, ERROR) and the clog2 function.
//  - Sub-module qos_fifo (DATA_W, FIFO_DEPTH): synchronous FIFO with occupancy output, instantiated
//    NUM_VC times in a generate loop. Router holds demux, FSM, thresholds, flags and counters.
// TESTING
//  1 reset low 3 cycles, release, init=1 with (7,2) then (5,1), init=0 -> thresholds 5/1 latched,
//    idle_out=1 after init falls.
//  2 push 0x024,0x060,0x070,0x0F3,0x54A,0x552,0x527,0x5B2,0xAAA,0xAEE,0xAEA,0xAFA,0xFAF,0xFD7,0xFAF,0xFFF
//    -> 4 words per VC, active_out=1, almost_empty=0 for all, almost_full=0 (4<5), no error.
//  3 pop all 4 VCs for 4 cycles -> data_out0 = 0x024,0x060,0x070,0x0F3 on successive cycles; VC3
//    ends 0xFFF; empty=4'hF; idle_out=1 one cycle after the last pop.
//  4 req=1, idx=0..4 -> valid=1 from the next cycle, data=4,4,4,4,16; idx=5 -> data=0.
//  5 push 9 words to VC1 (depth 8) -> ready_in=0 on the 9th, word dropped, error_out=1;
//    init pulse -> INIT, counters cleared, error_out=0.
//  6 pop VC2 while empty -> error_out=1; assert reset mid-burst -> all outputs at reset values.

Source files
------------

// File: rtl/qos_pkg.sv
// Shared definitions for the QoS virtual-channel router: FSM encoding and a
// constant-foldable ceil(log2) used to size channel-select and occupancy fields.
package qos_pkg;

    // Control FSM states; the *_out indicators decode IDLE/ACTIVE/ERROR directly.
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } qos_state_e;

    // ceil(log2(v)), usable in parameter declarations.
    function automatic int qos_clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < v) r = k + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/qos_fifo.sv
// Per-channel synchronous FIFO. Read data is registered and holds between
// reads. Exposes next-state occupancy so the router can register its flags
// from the value that will be in force after the current edge.
module qos_fifo
    import qos_pkg::*;
#(
    parameter  int DATA_W     = 12,
    parameter  int FIFO_DEPTH = 8,
    localparam int AW         = qos_clog2(FIFO_DEPTH),
    localparam int THR_W      = AW + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_rd,
    output logic [DATA_W-1:0] o_rdata,
    output logic [THR_W-1:0]  o_count_nxt,
    output logic              o_full,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [THR_W-1:0]  r_count;
    logic              w_wr_ok;
    logic              w_rd_ok;

    assign o_full  = (r_count == THR_W'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign w_wr_ok = i_wr && !o_full  && !i_clr;
    assign w_rd_ok = i_rd && !o_empty && !i_clr;

    // Occupancy after this edge; a clear wins over any concurrent access.
    always_comb begin
        o_count_nxt = r_count;
        if (w_wr_ok) o_count_nxt = o_count_nxt + THR_W'(1);
        if (w_rd_ok) o_count_nxt = o_count_nxt - THR_W'(1);
        if (i_clr)   o_count_nxt = '0;
    end

    // Storage array: no reset needed, validity is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (w_wr_ok) r_mem[r_wp] <= i_wdata;
    end

    // Pointers, occupancy and the registered read port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            o_rdata <= '0;
        end else if (i_clr) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            o_rdata <= '0;
        end else begin
            if (w_wr_ok) r_wp <= r_wp + AW'(1);
            if (w_rd_ok) begin
                o_rdata <= r_mem[r_rp];
                r_rp    <= r_rp + AW'(1);
            end
            r_count <= o_count_nxt;
        end
    end

endmodule

// File: rtl/qos_vc_router.sv
// QoS virtual-channel router: demuxes input words on their top VC_W bits into
// NUM_VC FIFOs, raises threshold flags, tracks popped-word counters and runs
// the RESET/INIT/IDLE/ACTIVE/ERROR control FSM with overflow/underflow trapping.
module qos_vc_router
    import qos_pkg::*;
#(
    parameter  int DATA_W     = 12,
    parameter  int NUM_VC     = 4,
    parameter  int FIFO_DEPTH = 8,
    parameter  int CNT_W      = 8,
    localparam int VC_W       = qos_clog2(NUM_VC),
    localparam int THR_W      = qos_clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic [THR_W-1:0]         umbral_high,
    input  logic [THR_W-1:0]         umbral_low,
    input  logic                     push,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     ready_in,
    input  logic [NUM_VC-1:0]        pop,
    output logic [NUM_VC*DATA_W-1:0] data_out,
    output logic [NUM_VC-1:0]        empty,
    output logic [NUM_VC-1:0]        almost_full,
    output logic [NUM_VC-1:0]        almost_empty,
    input  logic                     req,
    input  logic [VC_W:0]            idx,
    output logic                     valid,
    output logic [CNT_W-1:0]         data,
    output logic                     idle_out,
    output logic                     active_out,
    output logic                     error_out
);

    localparam logic [VC_W:0] IDX_TOTAL = (VC_W+1)'(NUM_VC);

    qos_state_e                         r_state;
    qos_state_e                         w_state_nxt;
    logic       [THR_W-1:0]             r_thr_hi;
    logic       [THR_W-1:0]             r_thr_lo;
    logic       [NUM_VC-1:0]            r_empty;
    logic       [NUM_VC-1:0]            r_af;
    logic       [NUM_VC-1:0]            r_ae;
    logic       [NUM_VC-1:0][CNT_W-1:0] r_vc_cnt;
    logic       [CNT_W-1:0]             r_total;
    logic                               r_valid;
    logic       [CNT_W-1:0]             r_data;

    logic       [VC_W-1:0]              w_vc;
    logic                               w_op_en;
    logic                               w_clr;
    logic                               w_push_ok;
    logic                               w_ovf;
    logic                               w_unf;
    logic                               w_all_empty_nxt;
    logic       [NUM_VC-1:0]            w_wr;
    logic       [NUM_VC-1:0]            w_rd;
    logic       [NUM_VC-1:0]            w_full;
    logic       [NUM_VC-1:0]            w_fempty;
    logic       [NUM_VC-1:0][DATA_W-1:0] w_dout;
    logic       [NUM_VC-1:0][THR_W-1:0]  w_occ_nxt;
    logic       [CNT_W:0]               w_tot_sum;

    // Channel select comes from the top bits of the word itself.
    assign w_vc     = data_in[DATA_W-1 -: VC_W];
    assign ready_in = !w_full[w_vc];

    // Traffic is honoured once the unit is programmed; RESET/INIT ignore it.
    assign w_op_en   = (r_state == S_IDLE) || (r_state == S_ACTIVE) || (r_state == S_ERROR);
    assign w_clr     = (r_state == S_INIT);
    assign w_push_ok = w_op_en && push && ready_in;
    assign w_ovf     = w_op_en && push && !ready_in;
    assign w_unf     = w_op_en && |(pop & w_fempty);

    // Per-channel write/read strobes; a pop on an empty channel is not bypassed.
    always_comb begin
        w_wr            = '0;
        w_rd            = '0;
        w_all_empty_nxt = 1'b1;
        for (int i = 0; i < NUM_VC; i++) begin
            w_wr[i] = w_push_ok && (w_vc == VC_W'(i));
            w_rd[i] = w_op_en && pop[i] && !w_fempty[i];
            if (w_occ_nxt[i] != '0) w_all_empty_nxt = 1'b0;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_VC; g++) begin : g_vc
            qos_fifo #(
                .DATA_W     (DATA_W),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .i_clk       (clk),
                .i_rst_n     (reset),
                .i_clr       (w_clr),
                .i_wr        (w_wr[g]),
                .i_wdata     (data_in),
                .i_rd        (w_rd[g]),
                .o_rdata     (w_dout[g]),
                .o_count_nxt (w_occ_nxt[g]),
                .o_full      (w_full[g]),
                .o_empty     (w_fempty[g])
            );
            assign data_out[g*DATA_W +: DATA_W] = w_dout[g];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_RESET;
        else        r_state <= w_state_nxt;
    end

    // Next-state: init dominates, then error trapping, then idle/active tracking.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RESET:  w_state_nxt = S_INIT;
            S_INIT:   if (!init) w_state_nxt = S_IDLE;
            S_IDLE: begin
                if (init)                w_state_nxt = S_INIT;
                else if (w_ovf || w_unf) w_state_nxt = S_ERROR;
                else if (w_push_ok)      w_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (init)                                w_state_nxt = S_INIT;
                else if (w_ovf || w_unf)                 w_state_nxt = S_ERROR;
                else if (w_all_empty_nxt && !w_push_ok)  w_state_nxt = S_IDLE;
            end
            S_ERROR:  if (init) w_state_nxt = S_INIT;
            default:  w_state_nxt = S_RESET;
        endcase
    end

    assign idle_out   = (r_state == S_IDLE);
    assign active_out = (r_state == S_ACTIVE);
    assign error_out  = (r_state == S_ERROR);

    // Thresholds are reprogrammed every INIT cycle while init is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_thr_hi <= '0;
            r_thr_lo <= '0;
        end else if ((r_state == S_INIT) && init) begin
            r_thr_hi <= umbral_high;
            r_thr_lo <= umbral_low;
        end
    end

    // Flags track post-edge occupancy; reset values match zero occupancy
    // compared against zero thresholds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_empty <= '1;
            r_af    <= '1;
            r_ae    <= '1;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                r_empty[i] <= (w_occ_nxt[i] == '0);
                r_af[i]    <= (w_occ_nxt[i] >= r_thr_hi);
                r_ae[i]    <= (w_occ_nxt[i] <= r_thr_lo);
            end
        end
    end

    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;

    // Total sum is one bit wider so saturation is a simple carry test.
    always_comb begin
        w_tot_sum = {1'b0, r_total};
        for (int i = 0; i < NUM_VC; i++) begin
            w_tot_sum = w_tot_sum + (CNT_W+1)'(w_rd[i]);
        end
    end

    // Saturating popped-word counters, cleared while initialising.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vc_cnt <= '0;
            r_total  <= '0;
        end else if (w_clr) begin
            r_vc_cnt <= '0;
            r_total  <= '0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                if (w_rd[i] && !(&r_vc_cnt[i])) r_vc_cnt[i] <= r_vc_cnt[i] + CNT_W'(1);
            end
            r_total <= w_tot_sum[CNT_W] ? '1 : w_tot_sum[CNT_W-1:0];
        end
    end

    // Counter read port: one-cycle latency, out-of-range index reads zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= req;
            if (req) begin
                if (idx < IDX_TOTAL)       r_data <= r_vc_cnt[idx[VC_W-1:0]];
                else if (idx == IDX_TOTAL) r_data <= r_total;
                else                       r_data <= '0;
            end
        end
    end

    assign valid = r_valid;
    assign data  = r_data;

endmodule
